// File: rtl/i2c_reg_config.sv
// i2c_reg_config: walks a {reg_addr, reg_data} table and feeds the byte-level
// i2c_master command interface. It handles the power-up wait, table-driven
// delay entries, NACK retry with error reporting, and restarts on start.
// Optional build macro I2C_CFG_READBACK_EN: each successful write is followed
// by a verify read; a read-data mismatch is retried like a NACK.
//
// state       | meaning
// ------------+---------------------------------------------------------
// PWR_WAIT    | count PWRUP_MS ms ticks after reset or start
// FETCH       | tbl_addr driven, table data not yet valid
// LATCH       | capture tbl_data, decode delay marker vs. write
// DELAY       | count reg_data ms ticks
// SEND        | one-cycle req for the current byte
// WAIT_DONE   | hold until done; check slave_ack / read data
// STOP_SEND   | one-cycle req for a STOP-only byte after a NACK
// STOP_WAIT   | hold until the STOP byte completes
// RETRY       | decide between another attempt and FAIL
// RETRY_WAIT  | 1 ms back-off before restarting the entry
// NEXT        | advance to the next entry or finish
// IDLE_DONE   | all entries written, config_done high
// FAIL        | an entry ran out of retries, error high
module i2c_reg_config #(
  parameter logic [6:0]              DEV_ADDR    = 7'h3C,
  parameter int                      ADDR_BYTES  = 2,
  parameter int                      NUM_REGS    = 256,
  parameter int                      TBL_AW      = 8,
  parameter int                      CLK_FREQ_HZ = 25_000_000,
  parameter int                      PWRUP_MS    = 20,
  parameter int                      MAX_RETRY   = 3,
  parameter logic [ADDR_BYTES*8-1:0] DELAY_ADDR  = '1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic [TBL_AW-1:0]        tbl_addr,
  input  logic [ADDR_BYTES*8+7:0]  tbl_data,
  output logic                     req,
  output logic [3:0]               cmd,
  output logic [7:0]               dout,
  input  logic                     done,
  input  logic                     slave_ack,
`ifdef I2C_CFG_READBACK_EN
  input  logic [7:0]               rd_data,
`endif
  output logic                     busy,
  output logic                     config_done,
  output logic                     error,
  output logic [TBL_AW-1:0]        err_index
);

  localparam int AW       = ADDR_BYTES * 8;
  localparam int TICK_MAX = CLK_FREQ_HZ / 1000 - 1;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX + 1) : 1;
  localparam int ATT_W    = $clog2(MAX_RETRY + 2);
  localparam int LAST_WR  = ADDR_BYTES + 1;
`ifdef I2C_CFG_READBACK_EN
  localparam int LAST_BYTE = 2 * ADDR_BYTES + 4;
`else
  localparam int LAST_BYTE = LAST_WR;
`endif

  localparam logic [3:0] C_START = 4'b0001;
  localparam logic [3:0] C_WRITE = 4'b0010;
  localparam logic [3:0] C_READ  = 4'b0100;
  localparam logic [3:0] C_STOP  = 4'b1000;

  typedef enum logic [3:0] {
    ST_PWR_WAIT, ST_FETCH, ST_LATCH, ST_DELAY, ST_SEND, ST_WAIT_DONE,
    ST_STOP_SEND, ST_STOP_WAIT, ST_RETRY, ST_RETRY_WAIT, ST_NEXT,
    ST_IDLE_DONE, ST_FAIL
  } state_t;

  state_t              state, state_n;
  logic [TBL_AW-1:0]   index, index_n;
  logic [3:0]          byte_idx, byte_idx_n;
  logic [ATT_W-1:0]    attempts, attempts_n;
  logic [15:0]         ms_cnt, ms_cnt_n;
  logic [TICK_W-1:0]   tick_cnt;
  logic                tick, tick_clr;
  logic [TBL_AW-1:0]   err_index_q, err_index_n;
  logic [AW-1:0]       reg_addr_q, reg_addr_n;
  logic [7:0]          reg_data_q, reg_data_n;
  logic [3:0]          byte_cmd;
  logic [7:0]          byte_dout;
  logic                is_read_byte;
  logic                rd_ok;

  assign tick = (tick_cnt == '0);

  // ms tick divider; restarted whenever a timed wait is entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt <= TICK_W'(TICK_MAX);
    else if (tick_clr || tick) tick_cnt <= TICK_W'(TICK_MAX);
    else tick_cnt <= tick_cnt - 1'b1;
  end

  // byte to present for the current byte_idx of the entry
  always_comb begin
    byte_cmd     = '0;
    byte_dout    = '0;
    is_read_byte = 1'b0;
    rd_ok        = 1'b1;
    if (byte_idx == 4'd0) begin
      byte_cmd  = C_START | C_WRITE;
      byte_dout = {DEV_ADDR, 1'b0};
    end
    if (byte_idx == 4'(LAST_WR)) begin
      byte_cmd  = C_WRITE | C_STOP;
      byte_dout = reg_data_q;
    end
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (byte_idx == 4'(1 + k)) begin
        byte_cmd  = C_WRITE;
        byte_dout = reg_addr_q[8*(ADDR_BYTES-1-k) +: 8];
      end
    end
`ifdef I2C_CFG_READBACK_EN
    if (byte_idx == 4'(LAST_WR + 1)) begin
      byte_cmd  = C_START | C_WRITE;
      byte_dout = {DEV_ADDR, 1'b0};
    end
    for (int k = 0; k < ADDR_BYTES; k++) begin
      if (byte_idx == 4'(LAST_WR + 2 + k)) begin
        byte_cmd  = C_WRITE;
        byte_dout = reg_addr_q[8*(ADDR_BYTES-1-k) +: 8];
      end
    end
    if (byte_idx == 4'(LAST_WR + ADDR_BYTES + 2)) begin
      // repeated start carrying the read address
      byte_cmd  = C_START | C_WRITE;
      byte_dout = {DEV_ADDR, 1'b1};
    end
    if (byte_idx == 4'(LAST_BYTE)) begin
      byte_cmd     = C_READ | C_STOP;
      byte_dout    = '0;
      is_read_byte = 1'b1;
    end
    rd_ok = (rd_data == reg_data_q);
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_PWR_WAIT;
    else state <= state_n;
  end

  // sequencer datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      index       <= '0;
      byte_idx    <= '0;
      attempts    <= '0;
      ms_cnt      <= 16'(PWRUP_MS);
      err_index_q <= '0;
      reg_addr_q  <= '0;
      reg_data_q  <= '0;
    end else begin
      index       <= index_n;
      byte_idx    <= byte_idx_n;
      attempts    <= attempts_n;
      ms_cnt      <= ms_cnt_n;
      err_index_q <= err_index_n;
      reg_addr_q  <= reg_addr_n;
      reg_data_q  <= reg_data_n;
    end
  end

  // next-state and datapath updates
  always_comb begin
    state_n     = state;
    index_n     = index;
    byte_idx_n  = byte_idx;
    attempts_n  = attempts;
    ms_cnt_n    = ms_cnt;
    err_index_n = err_index_q;
    reg_addr_n  = reg_addr_q;
    reg_data_n  = reg_data_q;
    tick_clr    = 1'b0;
    case (state)
      ST_PWR_WAIT: begin
        if (ms_cnt == '0) begin
          state_n = ST_FETCH;
          index_n = '0;
        end else if (tick) begin
          ms_cnt_n = ms_cnt - 1'b1;
        end
      end
      ST_FETCH: state_n = ST_LATCH;
      ST_LATCH: begin
        reg_addr_n = tbl_data[AW+7:8];
        reg_data_n = tbl_data[7:0];
        if (tbl_data[AW+7:8] == DELAY_ADDR) begin
          state_n  = ST_DELAY;
          ms_cnt_n = 16'(tbl_data[7:0]);
          tick_clr = 1'b1;
        end else begin
          state_n    = ST_SEND;
          byte_idx_n = '0;
        end
      end
      ST_DELAY: begin
        if (ms_cnt == '0) state_n = ST_NEXT;
        else if (tick) ms_cnt_n = ms_cnt - 1'b1;
      end
      ST_SEND: state_n = ST_WAIT_DONE;
      ST_WAIT_DONE: begin
        if (done) begin
          if (is_read_byte) begin
            // the read byte already carried STOP, so no extra STOP on mismatch
            state_n = rd_ok ? ST_NEXT : ST_RETRY;
          end else if (!slave_ack) begin
            state_n = ST_STOP_SEND;
          end else if (byte_idx == 4'(LAST_BYTE)) begin
            state_n = ST_NEXT;
          end else begin
            byte_idx_n = byte_idx + 1'b1;
            state_n    = ST_SEND;
          end
        end
      end
      ST_STOP_SEND: state_n = ST_STOP_WAIT;
      ST_STOP_WAIT: begin
        if (done) state_n = ST_RETRY;
      end
      ST_RETRY: begin
        if (attempts < ATT_W'(MAX_RETRY)) begin
          attempts_n = attempts + 1'b1;
          ms_cnt_n   = 16'd1;
          tick_clr   = 1'b1;
          state_n    = ST_RETRY_WAIT;
        end else begin
          err_index_n = index;
          state_n     = ST_FAIL;
        end
      end
      ST_RETRY_WAIT: begin
        if (ms_cnt == '0) begin
          byte_idx_n = '0;
          state_n    = ST_SEND;
        end else if (tick) begin
          ms_cnt_n = ms_cnt - 1'b1;
        end
      end
      ST_NEXT: begin
        attempts_n = '0;
        if (index == TBL_AW'(NUM_REGS - 1)) begin
          state_n = ST_IDLE_DONE;
        end else begin
          index_n = index + 1'b1;
          state_n = ST_FETCH;
        end
      end
      ST_IDLE_DONE, ST_FAIL: begin
        if (start) begin
          index_n    = '0;
          attempts_n = '0;
          ms_cnt_n   = 16'(PWRUP_MS);
          tick_clr   = 1'b1;
          state_n    = ST_PWR_WAIT;
        end
      end
      default: state_n = ST_PWR_WAIT;
    endcase
  end

  // outputs decoded from state; cmd/dout held for the whole byte
  always_comb begin
    req  = 1'b0;
    cmd  = '0;
    dout = '0;
    case (state)
      ST_SEND: begin
        req  = 1'b1;
        cmd  = byte_cmd;
        dout = byte_dout;
      end
      ST_WAIT_DONE: begin
        cmd  = byte_cmd;
        dout = byte_dout;
      end
      ST_STOP_SEND: begin
        req = 1'b1;
        cmd = C_STOP;
      end
      ST_STOP_WAIT: cmd = C_STOP;
      default: ;
    endcase
  end

  assign tbl_addr    = index;
  assign busy        = (state != ST_IDLE_DONE) && (state != ST_FAIL);
  assign config_done = (state == ST_IDLE_DONE);
  assign error       = (state == ST_FAIL);
  assign err_index   = err_index_q;

endmodule

// File: tb/tb_i2c_reg_config.sv
// Bench for i2c_reg_config: table ROM and byte-level master model, with an
// expected-byte queue built from the sequencing rules per run.
`timescale 1ns/1ps
module tb_i2c_reg_config;

  localparam int NREG = 6;
  localparam int MAXR = 3;
`ifdef I2C_CFG_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  tbl_addr;
  logic [23:0] tbl_data = '0;
  logic        req;
  logic [3:0]  cmd;
  logic [7:0]  dout;
  logic        done = 1'b0;
  logic        slave_ack = 1'b0;
`ifdef I2C_CFG_READBACK_EN
  logic [7:0]  rd_data = '0;
`endif
  logic        busy, config_done, error;
  logic [3:0]  err_index;

  i2c_reg_config #(
    .DEV_ADDR(7'h3C), .ADDR_BYTES(2), .NUM_REGS(NREG), .TBL_AW(4),
    .CLK_FREQ_HZ(10000), .PWRUP_MS(2), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .tbl_addr(tbl_addr), .tbl_data(tbl_data),
    .req(req), .cmd(cmd), .dout(dout), .done(done), .slave_ack(slave_ack),
`ifdef I2C_CFG_READBACK_EN
    .rd_data(rd_data),
`endif
    .busy(busy), .config_done(config_done), .error(error),
    .err_index(err_index)
  );

  always #5 clk = ~clk;

  logic [15:0] tbl_a [NREG];
  logic [7:0]  tbl_d [NREG];

  always @(posedge clk) begin
    if (int'(tbl_addr) < NREG) tbl_data <= {tbl_a[tbl_addr], tbl_d[tbl_addr]};
    else tbl_data <= '0;
  end

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int last_evt = 0;
  bit mute = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [3:0] c;
    logic [7:0] d;
    logic       ack;
    logic [7:0] rd;
    int         gap;
  } exp_t;
  exp_t expq[$];

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic check_ge(input string name, input int act, input int minv);
    checks++;
    if (act < minv) begin
      errors++;
      $display("FAIL %s: got %0d expected >= %0d (t=%0t)", name, act, minv, $time);
    end
  endtask

  task automatic push(input logic [3:0] c, input logic [7:0] d, input logic ack,
                      input logic [7:0] rd, input int gap);
    exp_t it;
    it.c = c; it.d = d; it.ack = ack; it.rd = rd; it.gap = gap;
    expq.push_back(it);
  endtask

  // Expected byte stream for one run. ne/nb/nn: NACK byte nb of entry ne on
  // its first nn attempts. rbe: entry whose first verify read returns bad data.
  task automatic build_run(input int ne, input int nb, input int nn, input int rbe,
                           output bit ef, output int ei);
    int g;
    g  = 20;
    ef = 1'b0;
    ei = 0;
    for (int i = 0; i < NREG; i++) begin
      bit ok;
      logic [7:0] wb [4];
      ok = 1'b0;
      if (tbl_a[i] == 16'hFFFF) begin
        g = g + 10 * int'(tbl_d[i]);
        continue;
      end
      wb[0] = 8'h78; wb[1] = tbl_a[i][15:8]; wb[2] = tbl_a[i][7:0]; wb[3] = tbl_d[i];
      for (int a = 0; a <= MAXR && !ok; a++) begin
        bit nack;
        logic [7:0] rdv;
        nack = (i == ne) && (a < nn);
        for (int b = 0; b < 4; b++) begin
          logic [3:0] c;
          c = (b == 0) ? 4'b0011 : (b == 3) ? 4'b1010 : 4'b0010;
          push(c, wb[b], !(nack && b == nb), 8'h00, g);
          g = 0;
          if (nack && b == nb) break;
        end
        if (nack) begin
          push(4'b1000, 8'h00, 1'b1, 8'h00, 0);
          g = 10;
          continue;
        end
        if (RB) begin
          rdv = (i == rbe && a == 0) ? (tbl_d[i] ^ 8'h02) : tbl_d[i];
          push(4'b0011, 8'h78, 1'b1, 8'h00, 0);
          push(4'b0010, wb[1], 1'b1, 8'h00, 0);
          push(4'b0010, wb[2], 1'b1, 8'h00, 0);
          push(4'b0011, 8'h79, 1'b1, 8'h00, 0);
          push(4'b1100, 8'h00, 1'b1, rdv, 0);
          if (rdv != tbl_d[i]) begin
            g = 10;
            continue;
          end
        end
        ok = 1'b1;
      end
      if (!ok) begin
        ef = 1'b1;
        ei = i;
        return;
      end
    end
  endtask

  task automatic rand_table(input int dly);
    tbl_a[0] = 16'h3008; tbl_d[0] = 8'h82;
    tbl_a[1] = 16'h3103; tbl_d[1] = 8'h03;
    tbl_a[2] = 16'hFFFF; tbl_d[2] = 8'(dly);
    for (int i = 3; i < NREG; i++) begin
      tbl_a[i] = 16'($urandom_range(0, 16'hFFFE));
      tbl_d[i] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    last_evt = cycle;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic finish_run(input string name, input bit ef, input int ei);
    int n;
    n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_busy_end"}, int'(busy), 0);
    check({name, "_queue_left"}, expq.size(), 0);
    check({name, "_config_done"}, int'(config_done), int'(!ef));
    check({name, "_error"}, int'(error), int'(ef));
    if (ef) check({name, "_err_index"}, int'(err_index), ei);
    expq.delete();
  endtask

  // master model / monitor: compares every requested byte, answers with done
  initial begin
    forever begin
      if (req && !mute) begin
        exp_t it;
        int   gap;
        int   lat;
        bit   held;
        gap = cycle - last_evt;
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got cmd=0x%0h dout=0x%0h expected no request", cmd, dout);
          it.c = cmd; it.d = dout; it.ack = 1'b1; it.rd = 8'h00; it.gap = 0;
        end else begin
          it = expq.pop_front();
          check("byte_cmd", int'(cmd), int'(it.c));
          check("byte_dout", int'(dout), int'(it.d));
          if (it.gap > 0) check_ge("req_gap", gap, it.gap);
        end
        lat  = $urandom_range(1, 4);
        held = 1'b1;
        repeat (lat) begin
          @(negedge clk);
          if (req) held = 1'b0;
        end
        check("req_low_while_waiting", int'(held), 1);
        done = 1'b1;
        slave_ack = it.ack;
`ifdef I2C_CFG_READBACK_EN
        rd_data = it.rd;
`endif
        @(negedge clk);
        done = 1'b0;
        slave_ack = 1'b0;
        last_evt = cycle;
      end else begin
        @(negedge clk);
      end
    end
  end

  initial begin
    bit ef;
    int ei;
    int e;
    int n;

    rand_table(5);
    repeat (3) @(negedge clk);
    #1;
    check("rst_tbl_addr", int'(tbl_addr), 0);
    check("rst_req", int'(req), 0);
    check("rst_cmd", int'(cmd), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_config_done", int'(config_done), 0);
    check("rst_error", int'(error), 0);
    check("rst_err_index", int'(err_index), 0);

    // run 1: all ACK, 5 ms delay entry (readback: one bad verify on entry 0)
    build_run(-1, 0, 0, 0, ef, ei);
    @(negedge clk);
    rst_n = 1'b1;
    last_evt = cycle;
    finish_run("run1", ef, ei);

    // run 2: data byte of entry 1 NACKed twice, then ACKed
    rand_table($urandom_range(0, 6));
    build_run(1, 3, 2, -1, ef, ei);
    do_start();
    finish_run("run2", ef, ei);

    // run 3: entry 3 always NACKed -> retries exhausted
    rand_table($urandom_range(0, 6));
    build_run(3, $urandom_range(0, 3), 99, -1, ef, ei);
    check("run3_model_fails", int'(ef), 1);
    do_start();
    finish_run("run3", 1'b1, 3);

    // run 4: restart from FAIL, all ACK
    rand_table($urandom_range(0, 6));
    build_run(-1, 0, 0, -1, ef, ei);
    do_start();
    finish_run("run4", ef, ei);

    // run 5: random NACK policy
    rand_table($urandom_range(0, 6));
    e = $urandom_range(0, 4);
    if (e >= 2) e++;
    build_run(e, $urandom_range(0, 3), $urandom_range(0, 4), -1, ef, ei);
    do_start();
    finish_run("run5", ef, ei);

    // run 6: async reset while waiting on done
    mute = 1'b1;
    do_start();
    n = 0;
    while (!req && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("run6_req_seen", int'(req), 1);
    @(negedge clk);
    @(negedge clk);
    check("run6_req_low_in_wait", int'(req), 0);
    rst_n = 1'b0;
    #1;
    check("run6_rst_req", int'(req), 0);
    check("run6_rst_busy", int'(busy), 1);
    check("run6_rst_config_done", int'(config_done), 0);
    check("run6_rst_error", int'(error), 0);
    check("run6_rst_tbl_addr", int'(tbl_addr), 0);

    // run 7: full sequence after reset release
    rand_table($urandom_range(0, 6));
    build_run(-1, 0, 0, -1, ef, ei);
    @(negedge clk);
    @(negedge clk);
    mute = 1'b0;
    rst_n = 1'b1;
    last_evt = cycle;
    finish_run("run7", ef, ei);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
